icache_direct: RTL
==================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, one-word-per-frame instruction cache between the datapath fetch port and the
//  instruction side (iREN/iaddr/iwait/iload) of memory_control. Hits return in the same cycle.
//  Misses issue one word read to memory_control, fill the frame and replay the lookup.
//  One instance per CPU; ports are the per-CPU slice of the cache_control bus.
// PARAMETERS
//  SETS    16  number of frames, power of 2, >=2; IDX_W = $clog2(SETS)
//  ADDR_W  32  byte address / word width
// PORTS
//  CLK       in   1       clock; all state updates on rising edge
//  RST       in   1       synchronous reset, active-high
//  imemREN   in   1       fetch request from datapath
//  imemaddr  in   ADDR_W  fetch byte address; bits [1:0] ignored
//  flush     in   1       invalidate all frames (1-cycle pulse)
//  ihit      out  1       imemload valid this cycle
//  imemload  out  ADDR_W  fetched instruction
//  iREN      out  1       read request to memory_control
//  iaddr     out  ADDR_W  word-aligned read address to memory_control
//  iwait     in   1       memory_control stall; 0 = iload valid this cycle
//  iload     in   ADDR_W  read data from memory_control
// BEHAVIOUR
//  - Clocking: one clock CLK; RST synchronous active-high. All flops reset on CLK edge with RST=1.
//  - Address split: idx = imemaddr[IDX_W+1:2], tag = imemaddr[ADDR_W-1:IDX_W+2].
//  - Storage per frame: valid (1), tag (ADDR_W-2-IDX_W), data (ADDR_W).
//  - Reset: all valid=0, state=IDLE, latched address=0. ihit=0, imemload=0, iREN=0, iaddr=0.
//  - FSM states and transitions:
//    - IDLE: hit = imemREN & valid[idx] & tag match (combinational).
//      - On hit: ihit=1, imemload=data[idx], no state change.
//      - On imemREN & !hit: latch {tag,idx}; next state FILL. ihit=0.
//    - FILL: iREN=1, iaddr={latched tag,idx,2'b00}; ihit=0, imemload=0.
//      - Stay while iwait=1.
//      - On iwait=0: write data=iload, tag and valid=1 into frame idx; next state IDLE.
//  - Miss latency: miss seen at cycle 0; iREN rises at cycle 1; iwait=0 at cycle N writes the frame;
//    the replayed lookup hits at cycle N+1 (no forwarding of iload to imemload).
//  - Fill commitment: a started fill always completes. imemaddr changes and imemREN deassertion
//    in FILL are ignored. The latched address is used.
//  - Outputs outside FILL: iREN=0, iaddr=0. imemload=0 whenever ihit=0.
//  - imemREN=0 in IDLE: ihit=0, no state change.
//  - flush: clears every valid bit next edge, in either state.
//    - Flush coinciding with the fill write (FILL, iwait=0): flush wins and the frame ends invalid.
//    - Flush in FILL with iwait=1: the fill continues, and its later write sets valid=1.
//  - Conflict miss: a new tag at an occupied idx overwrites that frame only after the fill completes.
//    The old contents remain hittable until then (not reachable, since the datapath is stalled).
//  - RST mid-FILL: next state IDLE with iREN=0 and all frames invalid. The outstanding request is
//    dropped; memory_control needs no cancel because iREN falls.
//  - Simultaneous RST and flush: RST dominates.
// TESTING
//  1. Reset, imemREN=1, imemaddr=0x0000_0040 -> cycle0 ihit=0; cycle1 iREN=1, iaddr=0x40;
//     iwait=0, iload=0x2001_0005 at cycle3 -> cycle4 ihit=1, imemload=0x2001_0005.
//  2. After 1, refetch 0x40 for 5 cycles -> ihit=1 each cycle, iREN never asserted.
//  3. Fill 0x40 (SETS=16, idx 0), then fetch 0x80 (same idx, new tag) -> miss, iaddr=0x80.
//     Refetch 0x40 -> miss again (conflict eviction).
//  4. Fill 0x44. Pulse flush with no fill active, then fetch 0x44 -> ihit=0, iREN=1 one cycle later.
//     Repeat with flush on the fill's iwait=0 cycle -> subsequent 0x44 still misses.
//  5. In FILL for 0x48 with iwait=1, change imemaddr to 0x100 and drop imemREN -> iaddr stays 0x48.
//     The frame for 0x48 is valid after iwait=0.
//  6. Assert RST while FILL with iwait=1 -> next cycle iREN=0, ihit=0.
//     Fetch of previously cached 0x40 misses.

Source files
------------

// File: rtl/icache_if.sv
// Per-CPU fetch-side bus of the instruction cache: datapath fetch port plus
// the instruction read channel toward memory_control.
interface icache_if #(
    parameter int ADDR_W = 32
);
    logic              imemREN;
    logic [ADDR_W-1:0] imemaddr;
    logic              flush;
    logic              ihit;
    logic [ADDR_W-1:0] imemload;
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [ADDR_W-1:0] iload;

    // Environment side: datapath requester and memory_control responder
    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    // Cache side
    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits answer in the
// lookup cycle; a miss fetches one word, fills the frame and replays the lookup.
module icache_direct #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic     CLK,
    input  logic     RST,
    icache_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SETS-1:0]    valid_r;
    logic [TAG_W-1:0]   tag_r  [SETS];
    logic [ADDR_W-1:0]  data_r [SETS];
    logic [IDX_W-1:0]   lat_idx_r;
    logic [TAG_W-1:0]   lat_tag_r;

    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               lookup_s;
    logic               hit_s;
    logic               miss_s;
    logic               fill_done_s;
    logic               ihit_s;
    logic [ADDR_W-1:0]  imemload_s;
    logic               iren_s;
    logic [ADDR_W-1:0]  iaddr_s;

    assign idx_s       = bus.imemaddr[IDX_W+1:2];
    assign tag_s       = bus.imemaddr[ADDR_W-1:IDX_W+2];
    assign lookup_s    = bus.imemREN & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
    assign hit_s       = lookup_s & (state_r == IDLE);
    assign miss_s      = bus.imemREN & ~lookup_s & (state_r == IDLE);
    assign fill_done_s = (state_r == FILL) & ~bus.iwait;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a started fill always runs to its iwait=0 cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_s) state_nxt_s = FILL;
                else        state_nxt_s = IDLE;
            end
            FILL: begin
                if (!bus.iwait) state_nxt_s = IDLE;
                else            state_nxt_s = FILL;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ihit_s     = 1'b0;
        imemload_s = {ADDR_W{1'b0}};
        iren_s     = 1'b0;
        iaddr_s    = {ADDR_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    ihit_s     = 1'b1;
                    imemload_s = data_r[idx_s];
                end else begin
                    ihit_s     = 1'b0;
                    imemload_s = {ADDR_W{1'b0}};
                end
            end
            FILL: begin
                iren_s  = 1'b1;
                iaddr_s = {lat_tag_r, lat_idx_r, 2'b00};
            end
            default: begin
                iren_s  = 1'b0;
                iaddr_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign bus.ihit     = ihit_s;
    assign bus.imemload = imemload_s;
    assign bus.iREN     = iren_s;
    assign bus.iaddr    = iaddr_s;

    // Miss address latch; held for the whole fill so fetch-port changes are ignored
    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_idx_r <= {IDX_W{1'b0}};
            lat_tag_r <= {TAG_W{1'b0}};
        end else if (miss_s) begin
            lat_idx_r <= idx_s;
            lat_tag_r <= tag_s;
        end else begin
            lat_idx_r <= lat_idx_r;
            lat_tag_r <= lat_tag_r;
        end
    end

    // Frame storage; flush is applied after the fill write so it wins a tie
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_r <= {SETS{1'b0}};
            for (int i = 0; i < SETS; i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                data_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            if (fill_done_s) begin
                tag_r[lat_idx_r]  <= lat_tag_r;
                data_r[lat_idx_r] <= bus.iload;
            end
            if (bus.flush) begin
                valid_r <= {SETS{1'b0}};
            end else if (fill_done_s) begin
                valid_r[lat_idx_r] <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end
    end
endmodule
